// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM encoding, key map and
// small decode helpers for active-low one-hot patterns.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_HELD    = 2'd2
  } kp_state_e;

  // Indexed by {row, col}; row-major so each group of four is one physical row.
  localparam logic [3:0] KEY_MAP [0:15] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'h0, 4'hF, 4'hE, 4'hD
  };

  function automatic logic one_low(input logic [3:0] v);
    case (v)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: one_low = 1'b1;
      default:                            one_low = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] v);
    case (v)
      4'b1110: low_index = 2'd0;
      4'b1101: low_index = 2'd1;
      4'b1011: low_index = 2'd2;
      4'b0111: low_index = 2'd3;
      default: low_index = 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] key_lookup(input logic [3:0] row_pat,
                                            input logic [3:0] col_pat);
    key_lookup = KEY_MAP[{low_index(row_pat), low_index(col_pat)}];
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Row synchronizer and column-period tick generator for the keypad scanner.
// tick is high for one clock every COL_CYCLES clocks.
module scan_timer #(
  parameter int COL_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] rs,
  output logic       tick
);

  localparam int CW = (COL_CYCLES > 1) ? $clog2(COL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(COL_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]    sync1_q, sync1_d;
  logic [3:0]    sync2_q, sync2_d;

  assign tick = (tick_cnt_q == CNT_LAST);
  assign rs   = sync2_q;

  always_comb begin
    sync1_d = row;
    sync2_d = sync1_q;
    if (tick) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_cnt_q <= '0;
      sync1_q    <= 4'b1111;
      sync2_q    <= 4'b1111;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column sweep, debounced press/release detection
// and a single-entry key holding register with ack/overrun handshake.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int COL_CYCLES     = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] col,
  input  logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held,
  output logic       overrun
);

  localparam logic [3:0] DEB_LIMIT = 4'(DEBOUNCE_SCANS);

  logic [3:0] rs;
  logic       tick;

  kp_state_e  state_q, state_d;
  logic [3:0] col_q, col_d;
  logic [3:0] lat_row_q, lat_row_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] rel_q, rel_d;
  logic       emit_q, emit_d;
  logic [3:0] emit_code_q, emit_code_d;
  logic [3:0] key_code_q, key_code_d;
  logic       key_valid_q, key_valid_d;
  logic       key_held_q, key_held_d;
  logic       overrun_q, overrun_d;
  logic [3:0] col_next_s;

  scan_timer #(.COL_CYCLES(COL_CYCLES)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .row  (row),
    .rs   (rs),
    .tick (tick)
  );

  assign col_next_s = {col_q[2:0], col_q[3]};

  // Scan / debounce FSM; the column stays parked while a candidate is confirmed or held.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    lat_row_d   = lat_row_q;
    cnt_d       = cnt_q;
    rel_d       = rel_q;
    emit_d      = 1'b0;
    emit_code_d = emit_code_q;
    key_held_d  = key_held_q;
    case (state_q)
      ST_SCAN: begin
        if (tick && one_low(rs)) begin
          lat_row_d = rs;
          cnt_d     = 4'd1;
          state_d   = ST_CONFIRM;
        end else if (tick) begin
          col_d = col_next_s;
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_CONFIRM: begin
        if (tick && (rs == lat_row_q)) begin
          if ((cnt_q + 4'd1) == DEB_LIMIT) begin
            emit_d      = 1'b1;
            emit_code_d = key_lookup(lat_row_q, col_q);
            state_d     = ST_HELD;
            key_held_d  = 1'b1;
            rel_d       = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else if (tick) begin
          state_d = ST_SCAN;
          col_d   = col_next_s;
          cnt_d   = 4'd0;
        end else begin
          state_d = ST_CONFIRM;
        end
      end
      ST_HELD: begin
        if (tick && (rs == 4'b1111)) begin
          if ((rel_q + 4'd1) == DEB_LIMIT) begin
            state_d    = ST_SCAN;
            key_held_d = 1'b0;
            col_d      = col_next_s;
            rel_d      = 4'd0;
          end else begin
            rel_d = rel_q + 4'd1;
          end
        end else if (tick) begin
          rel_d = 4'd0;
        end else begin
          state_d = ST_HELD;
        end
      end
      default: begin
        state_d    = ST_SCAN;
        col_d      = 4'b1110;
        key_held_d = 1'b0;
      end
    endcase
  end

  // Output register: an emit loads only when the slot is free or being acked.
  always_comb begin
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    overrun_d   = overrun_q;
    if (emit_q) begin
      if (!key_valid_q || key_ack) begin
        key_code_d  = emit_code_q;
        key_valid_d = 1'b1;
        overrun_d   = 1'b0;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (key_ack) begin
      key_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end else begin
      key_valid_d = key_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_SCAN;
      col_q       <= 4'b1110;
      lat_row_q   <= 4'b1111;
      cnt_q       <= 4'd0;
      rel_q       <= 4'd0;
      emit_q      <= 1'b0;
      emit_code_q <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      lat_row_q   <= lat_row_d;
      cnt_q       <= cnt_d;
      rel_q       <= rel_d;
      emit_q      <= emit_d;
      emit_code_q <= emit_code_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      overrun_q   <= overrun_d;
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model driven from col, compared
// once per column period against a tick-level behavioural model.
module tb_keypad_scanner;

  localparam int COLC = 4;
  localparam int DEB  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ack = 1'b0;
  logic        key_held;
  logic        overrun;
  logic [15:0] pressed = 16'h0000;

  int n_chk  = 0;
  int n_pass = 0;

  logic [3:0] kmap [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

  // Reference model state (tick granularity).
  int         m_phase;  // 0 scanning, 1 confirming, 2 held
  int         m_col;
  int         m_cnt;
  int         m_rel;
  logic [3:0] m_lat;
  bit         m_emit;
  logic [3:0] m_emit_code;
  logic [3:0] m_code;
  bit         m_kv;
  bit         m_ov;

  always #5 clk = ~clk;

  keypad_scanner #(.COL_CYCLES(COLC), .DEBOUNCE_SCANS(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .col       (col),
    .row       (row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .key_held  (key_held),
    .overrun   (overrun)
  );

  // Pressed switch shorts its row to its column when that column is driven low.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && (col[c] == 1'b0)) row[r] = 1'b0;
  end

  task automatic check_value(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] key(input int r, input int c);
    logic [15:0] v;
    v = 16'h0000;
    v[r*4+c] = 1'b1;
    return v;
  endfunction

  function automatic logic [3:0] pattern(input logic [15:0] p, input int c);
    logic [3:0] v;
    for (int r = 0; r < 4; r++) v[r] = ~p[r*4+c];
    return v;
  endfunction

  function automatic int zero_pos(input logic [3:0] v);
    int idx;
    idx = 0;
    for (int r = 0; r < 4; r++) if (v[r] == 1'b0) idx = r;
    return idx;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_col = 0; m_cnt = 0; m_rel = 0; m_lat = 4'hF;
    m_emit = 0; m_emit_code = 4'h0; m_code = 4'h0; m_kv = 0; m_ov = 0;
  endtask

  task automatic model_tick();
    logic [3:0] rs_m;
    rs_m = pattern(pressed, m_col);
    m_emit = 0;
    case (m_phase)
      0: begin
        if ($countones(~rs_m) == 1) begin
          m_lat = rs_m; m_cnt = 1; m_phase = 1;
        end else m_col = (m_col + 1) % 4;
      end
      1: begin
        if (rs_m == m_lat) begin
          m_cnt++;
          if (m_cnt == DEB) begin
            m_emit = 1; m_emit_code = kmap[zero_pos(m_lat)][m_col];
            m_phase = 2; m_rel = 0;
          end
        end else begin
          m_phase = 0; m_col = (m_col + 1) % 4;
        end
      end
      default: begin
        if (rs_m == 4'b1111) m_rel++;
        else m_rel = 0;
        if (m_rel == DEB) begin
          m_phase = 0; m_col = (m_col + 1) % 4;
        end
      end
    endcase
  endtask

  task automatic model_edge(input bit ack);
    if (m_emit) begin
      if (!m_kv || ack) begin
        m_code = m_emit_code; m_kv = 1; m_ov = 0;
      end else m_ov = 1;
      m_emit = 0;
    end else if (ack) begin
      m_kv = 0; m_ov = 0;
    end
  endtask

  task automatic compare_all();
    logic [3:0] ec;
    ec = 4'b1111;
    ec[m_col] = 1'b0;
    check_value("col", col, ec);
    check_value("key_code", key_code, m_code);
    check_value("key_valid", {3'b000, key_valid}, {3'b000, m_kv});
    check_value("key_held", {3'b000, key_held}, {3'b000, (m_phase == 2)});
    check_value("overrun", {3'b000, overrun}, {3'b000, m_ov});
  endtask

  // One column period, entered just after a tick edge and ending on the next tick edge.
  task automatic run_window(input logic [15:0] p, input bit a1, input bit a2);
    #1; pressed = p; key_ack = a1;
    @(posedge clk); model_edge(a1);
    #1; key_ack = 1'b0;
    @(negedge clk); compare_all();
    @(posedge clk); #1; key_ack = a2;
    @(posedge clk); model_edge(a2);
    #1; key_ack = 1'b0;
    @(posedge clk); model_tick();
  endtask

  task automatic do_reset();
    #1; rst = 1'b0; key_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_value("rst_col", col, 4'b1110);
    check_value("rst_key_code", key_code, 4'h0);
    check_value("rst_key_valid", {3'b000, key_valid}, 4'h0);
    check_value("rst_key_held", {3'b000, key_held}, 4'h0);
    check_value("rst_overrun", {3'b000, overrun}, 4'h0);
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_value("col_before_first_tick", col, 4'b1110);
    @(posedge clk); model_tick();
  endtask

  initial begin
    logic [15:0] p;
    int sel;
    model_reset();
    do_reset();

    // Press 5, then acknowledge.
    repeat (12) run_window(key(1, 1), 1'b0, 1'b0);
    check_value("press5_code", key_code, 4'h5);
    check_value("press5_valid", {3'b000, key_valid}, 4'h1);
    check_value("press5_held", {3'b000, key_held}, 4'h1);
    run_window(key(1, 1), 1'b0, 1'b1);
    run_window(key(1, 1), 1'b0, 1'b0);
    check_value("press5_acked", {3'b000, key_valid}, 4'h0);
    repeat (8) run_window(16'h0000, 1'b0, 1'b0);
    check_value("press5_released", {3'b000, key_held}, 4'h0);

    // One-tick bounce on row0 under col3.
    for (int i = 0; i < 8 && !(m_col == 3 && m_phase == 0); i++)
      run_window(16'h0000, 1'b0, 1'b0);
    run_window(key(0, 3), 1'b0, 1'b0);
    run_window(16'h0000, 1'b0, 1'b0);
    run_window(16'h0000, 1'b0, 1'b0);
    check_value("bounce_col0", col, 4'b1110);
    check_value("bounce_no_key", {3'b000, key_valid}, 4'h0);

    // Overrun: 1 accepted, 9 dropped.
    repeat (12) run_window(key(0, 0), 1'b0, 1'b0);
    repeat (8) run_window(16'h0000, 1'b0, 1'b0);
    repeat (12) run_window(key(2, 2), 1'b0, 1'b0);
    check_value("ovr_code_kept", key_code, 4'h1);
    check_value("ovr_flag", {3'b000, overrun}, 4'h1);
    run_window(key(2, 2), 1'b0, 1'b1);
    run_window(key(2, 2), 1'b0, 1'b0);
    check_value("ovr_ack_valid", {3'b000, key_valid}, 4'h0);
    check_value("ovr_ack_flag", {3'b000, overrun}, 4'h0);
    repeat (8) run_window(16'h0000, 1'b0, 1'b0);

    // Ghost: rows 0 and 2 low on the same column.
    repeat (12) run_window(key(0, 1) | key(2, 1), 1'b0, 1'b0);
    check_value("ghost_no_key", {3'b000, key_valid}, 4'h0);
    check_value("ghost_not_held", {3'b000, key_held}, 4'h0);
    repeat (2) run_window(16'h0000, 1'b0, 1'b0);

    // Reset while holding D, then re-detection.
    repeat (12) run_window(key(3, 3), 1'b0, 1'b0);
    check_value("d_held", {3'b000, key_held}, 4'h1);
    do_reset();
    repeat (12) run_window(key(3, 3), 1'b0, 1'b0);
    check_value("d_redetect_code", key_code, 4'hD);
    check_value("d_redetect_valid", {3'b000, key_valid}, 4'h1);
    repeat (8) run_window(16'h0000, 1'b0, 1'b0);

    // Emit coinciding with ack while key_valid is still set.
    for (int i = 0; i < 12; i++) run_window(key(2, 0), m_emit, 1'b0);
    check_value("simul_code", key_code, 4'h7);
    check_value("simul_valid", {3'b000, key_valid}, 4'h1);
    check_value("simul_overrun", {3'b000, overrun}, 4'h0);
    repeat (8) run_window(16'h0000, 1'b0, 1'b0);

    // Randomized keypad activity.
    p = 16'h0000;
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        sel = $urandom_range(0, 99);
        if (sel < 40) p = 16'h0000;
        else if (sel < 85) p = key($urandom_range(0, 3), $urandom_range(0, 3));
        else p = key($urandom_range(0, 3), $urandom_range(0, 3)) |
                 key($urandom_range(0, 3), $urandom_range(0, 3));
      end
      if ($urandom_range(0, 79) == 0) do_reset();
      run_window(p, ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got %0d checks, expected completion", n_chk);
    $fatal(1);
  end

endmodule
